collatz_engine_param: RTL and testbench
=======================================

Name: collatz_engine_param

Overview:
Parametrised, handshaked successor to the fixed 8-bit Collatz datapath.
- Accepts a seed of DATA_WIDTH bits and iterates n -> n/2 (even) or n -> 3n+1 (odd), one operation per clock, until n == 1.
- Reports step count, error flags and, optionally, the peak trajectory value.
- Sits behind the chip-level I/O wrapper; the top level maps its buses onto ui_in/uo_out/uio.

Parameters:
DATA_WIDTH, 8, seed width
CALC_WIDTH, 16, internal iterate width; must be >= DATA_WIDTH
STEP_WIDTH, 8, step counter width

Ports:
BB_SYSTEM_CLOCK_50  input  1  system clock, rising edge
BB_SYSTEM_RESET_InHigh  input  1  synchronous active-high reset
BB_SYSTEM_start_In  input  1  start request; sampled only in IDLE
BB_SYSTEM_data_InBUS  input  DATA_WIDTH  seed, sampled with start
BB_SYSTEM_busy_Out  output  1  high while computing
BB_SYSTEM_done_Out  output  1  one-cycle pulse when the result is valid
BB_SYSTEM_data_OutBUS  output  STEP_WIDTH  step count of last run, saturating
BB_SYSTEM_stepsat_Out  output  1  step count saturated during last run
BB_SYSTEM_ovf_Out  output  1  3n+1 exceeded CALC_WIDTH; run aborted
BB_SYSTEM_zero_Out  output  1  seed was 0; run rejected

Behaviour:
Decided: one clock BB_SYSTEM_CLOCK_50; reset BB_SYSTEM_RESET_InHigh, synchronous, active-high.

Reset:
- On any edge with reset high: state IDLE, all outputs 0, iterate and counter cleared.
- Reset has priority over every other event, including mid-run.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and seed != 0: load n = zero-extended seed; clear steps, stepsat, ovf, zero; busy=1; go RUN.
  - start=1 and seed == 0: set zero=1; clear the others; go DONE.
  - start=0: stay IDLE; result outputs hold.
- RUN, one operation per edge:
  - n == 1: go DONE; n and steps unchanged.
  - n even: n <= n >> 1; steps++.
  - n odd: compute 3n+1 at CALC_WIDTH+2 bits.
    - Upper 2 bits nonzero: ovf=1, go DONE; steps not incremented.
    - Otherwise: n <= 3n+1; steps++.
  - Step counter at all-ones when an increment is due: hold the value, stepsat=1, keep iterating.
- DONE:
  - done=1 for exactly one cycle; busy=0; go IDLE.
  - data_OutBUS, stepsat, ovf, zero hold until the next accepted start or reset.

Timing:
- Start accepted at edge k: busy is high after edge k.
- done is high in the cycle after edge k+S+1, where S = steps performed (valid seed, no overflow).
- Seed 1: done after edge k+1, steps 0.
- Zero seed: done after edge k+1.
- Overflow detected at edge j: done after edge j+1.
- start while busy or in DONE: ignored.
- start high in the same cycle done is high: not accepted; state is DONE, not IDLE.
- data_InBUS is not required stable after the accepting edge.

Optional Feature:
Macro COLLATZ_PEAK_EN.
- Defined:
  - Adds output BB_SYSTEM_peak_OutBUS, width CALC_WIDTH: maximum n reached during the run, including the seed.
  - Set to the seed on start; updated each RUN edge with max(peak, new n).
  - Holds like the other results; 0 on reset and on zero-seed runs.
  - On overflow, holds the max of the in-range values.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then seed 6 with start pulse -> busy 8 cycles after accept, done after edge k+9, steps=8, flags 0, peak=16.
- Seed 27 (defaults) -> steps=111, stepsat=0, ovf=0, peak=9232; seed 1 -> steps=0, done after edge k+1.
- Seed 0 -> zero=1, steps=0, done one cycle after accept, busy never high.
- CALC_WIDTH=8, seed 27 -> ovf=1 when n=107 (3n+1=322), steps=11, done pulse; then seed 6 clears ovf and gives steps=8.
- STEP_WIDTH=4, seed 27 -> steps=15, stepsat=1, done timing unchanged (run completes); start pulses while busy are ignored.
- Seed 27, reset asserted 10 cycles after accept -> next edge: busy=0, done=0, all results 0; new start with seed 6 gives a correct result.

Source files
------------

// File: rtl/collatz_engine_param.sv
// Handshaked Collatz iterator: counts steps from a seed down to 1, flags zero seeds,
// 3n+1 overflow and step-count saturation. Define COLLATZ_PEAK_EN to add the peak output.
module collatz_engine_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CALC_WIDTH = 16,
  parameter int unsigned STEP_WIDTH = 8
) (
  input  logic                  BB_SYSTEM_CLOCK_50,
  input  logic                  BB_SYSTEM_RESET_InHigh,
  input  logic                  BB_SYSTEM_start_In,
  input  logic [DATA_WIDTH-1:0] BB_SYSTEM_data_InBUS,
  output logic                  BB_SYSTEM_busy_Out,
  output logic                  BB_SYSTEM_done_Out,
  output logic [STEP_WIDTH-1:0] BB_SYSTEM_data_OutBUS,
  output logic                  BB_SYSTEM_stepsat_Out,
  output logic                  BB_SYSTEM_ovf_Out,
`ifdef COLLATZ_PEAK_EN
  output logic [CALC_WIDTH-1:0] BB_SYSTEM_peak_OutBUS,
`endif
  output logic                  BB_SYSTEM_zero_Out
);

  localparam int unsigned XW = CALC_WIDTH + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CALC_WIDTH-1:0] n_q, n_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic                  stepsat_q, stepsat_d;
  logic                  ovf_q, ovf_d;
  logic                  zero_q, zero_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef COLLATZ_PEAK_EN
  logic [CALC_WIDTH-1:0] peak_q, peak_d;
`endif

  // 3n+1 carried two bits wider so overflow out of CALC_WIDTH is visible
  logic [XW-1:0] n_ext_c, triple_c;
  logic          n_one_c, steps_full_c;
  assign n_ext_c      = XW'(n_q);
  assign triple_c     = (n_ext_c << 1) + n_ext_c + XW'(1);
  assign n_one_c      = (n_q == CALC_WIDTH'(1));
  assign steps_full_c = &steps_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    steps_d   = steps_q;
    stepsat_d = stepsat_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef COLLATZ_PEAK_EN
    peak_d    = peak_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (BB_SYSTEM_start_In) begin
          steps_d   = '0;
          stepsat_d = 1'b0;
          ovf_d     = 1'b0;
          if (BB_SYSTEM_data_InBUS != '0) begin
            n_d     = CALC_WIDTH'(BB_SYSTEM_data_InBUS);
            zero_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_RUN;
`ifdef COLLATZ_PEAK_EN
            peak_d  = CALC_WIDTH'(BB_SYSTEM_data_InBUS);
`endif
          end else begin
            n_d     = '0;
            zero_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
`ifdef COLLATZ_PEAK_EN
            peak_d  = '0;
`endif
          end
        end
      end
      S_RUN: begin
        if (n_one_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (n_q[0] && (triple_c[XW-1:XW-2] != 2'b00)) begin
          // abort: done is raised on the following edge from S_DONE
          ovf_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          if (n_q[0]) begin
            n_d = triple_c[CALC_WIDTH-1:0];
`ifdef COLLATZ_PEAK_EN
            if (triple_c[CALC_WIDTH-1:0] > peak_q) peak_d = triple_c[CALC_WIDTH-1:0];
`endif
          end else begin
            n_d = n_q >> 1;
          end
          if (steps_full_c) stepsat_d = 1'b1;
          else              steps_d   = steps_q + STEP_WIDTH'(1);
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
        if (done_q) state_d = S_IDLE;
        else        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge BB_SYSTEM_CLOCK_50) begin
    if (BB_SYSTEM_RESET_InHigh) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      steps_q   <= '0;
      stepsat_q <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef COLLATZ_PEAK_EN
      peak_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      steps_q   <= steps_d;
      stepsat_q <= stepsat_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef COLLATZ_PEAK_EN
      peak_q    <= peak_d;
`endif
    end
  end

  assign BB_SYSTEM_busy_Out    = busy_q;
  assign BB_SYSTEM_done_Out    = done_q;
  assign BB_SYSTEM_data_OutBUS = steps_q;
  assign BB_SYSTEM_stepsat_Out = stepsat_q;
  assign BB_SYSTEM_ovf_Out     = ovf_q;
  assign BB_SYSTEM_zero_Out    = zero_q;
`ifdef COLLATZ_PEAK_EN
  assign BB_SYSTEM_peak_OutBUS = peak_q;
`endif

endmodule

// File: tb/tb_collatz_engine_param.sv
// Directed bench for collatz_engine_param: default, CALC_WIDTH=8 and STEP_WIDTH=4 instances.
module tb_collatz_engine_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [7:0] din;

  logic [2:0] busy_v, done_v, stepsat_v, ovf_v, zero_v;
  logic [7:0] steps0, steps1;
  logic [3:0] steps2;
`ifdef COLLATZ_PEAK_EN
  logic [15:0] peak0, peak2;
  logic [7:0]  peak1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  collatz_engine_param u_def (
    .BB_SYSTEM_CLOCK_50(clk), .BB_SYSTEM_RESET_InHigh(rst),
    .BB_SYSTEM_start_In(start_v[0]), .BB_SYSTEM_data_InBUS(din),
    .BB_SYSTEM_busy_Out(busy_v[0]), .BB_SYSTEM_done_Out(done_v[0]),
    .BB_SYSTEM_data_OutBUS(steps0), .BB_SYSTEM_stepsat_Out(stepsat_v[0]),
    .BB_SYSTEM_ovf_Out(ovf_v[0]),
`ifdef COLLATZ_PEAK_EN
    .BB_SYSTEM_peak_OutBUS(peak0),
`endif
    .BB_SYSTEM_zero_Out(zero_v[0])
  );

  collatz_engine_param #(.CALC_WIDTH(8)) u_c8 (
    .BB_SYSTEM_CLOCK_50(clk), .BB_SYSTEM_RESET_InHigh(rst),
    .BB_SYSTEM_start_In(start_v[1]), .BB_SYSTEM_data_InBUS(din),
    .BB_SYSTEM_busy_Out(busy_v[1]), .BB_SYSTEM_done_Out(done_v[1]),
    .BB_SYSTEM_data_OutBUS(steps1), .BB_SYSTEM_stepsat_Out(stepsat_v[1]),
    .BB_SYSTEM_ovf_Out(ovf_v[1]),
`ifdef COLLATZ_PEAK_EN
    .BB_SYSTEM_peak_OutBUS(peak1),
`endif
    .BB_SYSTEM_zero_Out(zero_v[1])
  );

  collatz_engine_param #(.STEP_WIDTH(4)) u_s4 (
    .BB_SYSTEM_CLOCK_50(clk), .BB_SYSTEM_RESET_InHigh(rst),
    .BB_SYSTEM_start_In(start_v[2]), .BB_SYSTEM_data_InBUS(din),
    .BB_SYSTEM_busy_Out(busy_v[2]), .BB_SYSTEM_done_Out(done_v[2]),
    .BB_SYSTEM_data_OutBUS(steps2), .BB_SYSTEM_stepsat_Out(stepsat_v[2]),
    .BB_SYSTEM_ovf_Out(ovf_v[2]),
`ifdef COLLATZ_PEAK_EN
    .BB_SYSTEM_peak_OutBUS(peak2),
`endif
    .BB_SYSTEM_zero_Out(zero_v[2])
  );

  function automatic logic [31:0] get_steps(input int i);
    case (i)
      0:       return 32'(steps0);
      1:       return 32'(steps1);
      default: return 32'(steps2);
    endcase
  endfunction

`ifdef COLLATZ_PEAK_EN
  function automatic logic [31:0] get_peak(input int i);
    case (i)
      0:       return 32'(peak0);
      1:       return 32'(peak1);
      default: return 32'(peak2);
    endcase
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a seed on instance i; returns just after the accepting edge k
  task automatic accept(input int i, input logic [7:0] seed);
    din        = seed;
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    din        = 8'hA5;
  endtask

  // Wait for done on instance i; lat = edge index after k where done is seen, -1 on timeout.
  // A rejected start pulse with seed 6 is injected before edge k+ign when ign > 0.
  task automatic wait_done(input int i, input int maxc, input int ign,
                           output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int c = 1; c <= maxc; c++) begin
      if (c == ign) begin
        din = 8'd6;
        start_v[i] = 1'b1;
      end
      tick();
      start_v[i] = 1'b0;
      if (busy_v[i]) busy_cnt++;
      if (done_v[i]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input int i, input string tag);
    check({tag, "_busy"}, 32'(busy_v[i]), 32'd0);
    check({tag, "_done"}, 32'(done_v[i]), 32'd0);
    check({tag, "_steps"}, get_steps(i), 32'd0);
    check({tag, "_flags"}, 32'({stepsat_v[i], ovf_v[i], zero_v[i]}), 32'd0);
`ifdef COLLATZ_PEAK_EN
    check({tag, "_peak"}, get_peak(i), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    rst     = 1'b1;
    start_v = 3'b000;
    din     = 8'd0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) check_all_zero(i, "reset");
    rst = 1'b0;
    tick();

    // seed 6: 6,3,10,5,16,8,4,2,1 -> 8 steps, done after k+9
    accept(0, 8'd6);
    check("s6_busy_k", 32'(busy_v[0]), 32'd1);
    wait_done(0, 200, 0, lat, bc);
    check("s6_lat", 32'(lat), 32'd9);
    check("s6_busy_cycles", 32'(bc), 32'd8);
    check("s6_busy_at_done", 32'(busy_v[0]), 32'd0);
    check("s6_steps", get_steps(0), 32'd8);
    check("s6_flags", 32'({stepsat_v[0], ovf_v[0], zero_v[0]}), 32'd0);
`ifdef COLLATZ_PEAK_EN
    check("s6_peak", get_peak(0), 32'd16);
`endif
    tick();
    check("s6_done_pulse", 32'(done_v[0]), 32'd0);
    check("s6_steps_hold", get_steps(0), 32'd8);

    // seed 27: 111 steps, peak 9232
    accept(0, 8'd27);
    wait_done(0, 300, 0, lat, bc);
    check("s27_lat", 32'(lat), 32'd112);
    check("s27_steps", get_steps(0), 32'd111);
    check("s27_flags", 32'({stepsat_v[0], ovf_v[0], zero_v[0]}), 32'd0);
`ifdef COLLATZ_PEAK_EN
    check("s27_peak", get_peak(0), 32'd9232);
`endif
    tick();

    // seed 1: no steps, done after k+1
    accept(0, 8'd1);
    wait_done(0, 20, 0, lat, bc);
    check("s1_lat", 32'(lat), 32'd1);
    check("s1_steps", get_steps(0), 32'd0);
    check("s1_busy_cycles", 32'(bc), 32'd0);
    tick();

    // seed 0: rejected, zero flag, busy never high
    accept(0, 8'd0);
    check("s0_busy_k", 32'(busy_v[0]), 32'd0);
    wait_done(0, 20, 0, lat, bc);
    check("s0_lat", 32'(lat), 32'd1);
    check("s0_busy_cycles", 32'(bc), 32'd0);
    check("s0_zero", 32'(zero_v[0]), 32'd1);
    check("s0_steps", get_steps(0), 32'd0);
`ifdef COLLATZ_PEAK_EN
    check("s0_peak", get_peak(0), 32'd0);
`endif
    // start while done is high must not be accepted
    accept(0, 8'd6);
    check("done_start_busy", 32'(busy_v[0]), 32'd0);
    check("done_start_zero_hold", 32'(zero_v[0]), 32'd1);
    tick();
    check("done_start_still_idle", 32'(busy_v[0]), 32'd0);

    // CALC_WIDTH=8, seed 27: n=107 after 11 steps, 3*107+1=322 overflows at k+12
    accept(1, 8'd27);
    wait_done(1, 200, 0, lat, bc);
    check("c8_lat", 32'(lat), 32'd13);
    check("c8_ovf", 32'(ovf_v[1]), 32'd1);
    check("c8_steps", get_steps(1), 32'd11);
    check("c8_busy_cycles", 32'(bc), 32'd11);
`ifdef COLLATZ_PEAK_EN
    check("c8_peak", get_peak(1), 32'd214);
`endif
    tick();
    accept(1, 8'd6);
    check("c8_ovf_cleared", 32'(ovf_v[1]), 32'd0);
    wait_done(1, 200, 0, lat, bc);
    check("c8_s6_lat", 32'(lat), 32'd9);
    check("c8_s6_steps", get_steps(1), 32'd8);
    check("c8_s6_ovf", 32'(ovf_v[1]), 32'd0);
    tick();

    // STEP_WIDTH=4, seed 27: saturates at 15, run length unchanged; start mid-run ignored
    accept(2, 8'd27);
    wait_done(2, 300, 4, lat, bc);
    check("s4_lat", 32'(lat), 32'd112);
    check("s4_steps", get_steps(2), 32'd15);
    check("s4_stepsat", 32'(stepsat_v[2]), 32'd1);
    check("s4_ovf", 32'(ovf_v[2]), 32'd0);
    tick();

    // reset 10 cycles into a seed-27 run
    accept(0, 8'd27);
    for (int c = 0; c < 10; c++) tick();
    check("mid_busy_before_rst", 32'(busy_v[0]), 32'd1);
    check("mid_steps_before_rst", get_steps(0), 32'd10);
    rst = 1'b1;
    tick();
    check_all_zero(0, "mid_rst");
    rst = 1'b0;
    tick();
    accept(0, 8'd6);
    wait_done(0, 200, 0, lat, bc);
    check("post_rst_lat", 32'(lat), 32'd9);
    check("post_rst_steps", get_steps(0), 32'd8);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
